// File: rtl/riscv_pkg.sv
// Shared RV32 core types: datapath widths and the fetch-stage interface types.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_e;

    // Instruction-memory request channel.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } imem_req_t;

    // Instruction-memory response channel.
    typedef struct packed {
        logic            valid;
        logic [ILEN-1:0] data;
    } imem_rsp_t;

    // Fetch-to-decode channel.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_out_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps at most one imem request in
// flight, holds one returned instruction for decode, and applies execute-stage
// redirects while discarding wrong-path responses.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets are
// replaced by TRAP_PC and reported with a one-cycle fetch_misalign_o pulse.
module pc_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
`endif
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_pc_o,
    output logic [ILEN-1:0] if_instr_o
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misalign_o
`endif
);

    fetch_state_e    state_q;
    logic            req_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic [XLEN-1:0] buf_pc_q;
    logic [ILEN-1:0] buf_instr_q;
    logic            buf_valid_q;

    imem_req_t       req;
    imem_rsp_t       rsp;
    if_out_t         if_out;
    logic            req_hs;
    logic [XLEN-1:0] redirect_tgt;

    // Bundle the channels so the rest of the logic reads in pipeline terms.
    assign req    = '{valid: req_valid_q, addr: pc_q};
    assign rsp    = '{valid: imem_rsp_valid_i, data: imem_rsp_data_i};
    assign if_out = '{valid: buf_valid_q, pc: buf_pc_q, instr: buf_instr_q};
    assign req_hs = req.valid && imem_req_ready_i;

    assign imem_req_valid_o = req.valid;
    assign imem_req_addr_o  = req.addr;
    assign if_valid_o       = if_out.valid;
    assign if_pc_o          = if_out.pc;
    assign if_instr_o       = if_out.instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redirect_misaligned;
    logic misalign_q;

    assign redirect_misaligned = redirect_pc_i[1:0] != 2'b00;
    assign redirect_tgt        = redirect_misaligned ? TRAP_PC : redirect_pc_i;
    assign fetch_misalign_o    = misalign_q;

    // One-cycle pulse in the cycle after a misaligned redirect is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid_i && redirect_misaligned;
        end
    end
`else
    // Targets pass through untouched, low bits included.
    assign redirect_tgt = redirect_pc_i;
`endif

    // Fetch FSM: sequential PC advance, response capture, decode hand-off and
    // redirect handling. A redirect always overrides the sequential PC+4.
    // req_valid_q is registered so the request comes up one cycle after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_REQ;
            req_valid_q   <= 1'b0;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            buf_pc_q      <= '0;
            buf_instr_q   <= '0;
            buf_valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (redirect_valid_i) begin
                        // Accepted request (if any) is wrong-path; retract or flush it.
                        pc_q <= redirect_tgt;
                        if (req_hs) begin
                            state_q     <= S_FLUSH;
                            req_valid_q <= 1'b0;
                        end else begin
                            req_valid_q <= 1'b1;
                        end
                    end else if (req_hs) begin
                        inflight_pc_q <= pc_q;
                        pc_q          <= pc_q + XLEN'(4);
                        state_q       <= S_WAIT;
                        req_valid_q   <= 1'b0;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid_i) begin
                        pc_q <= redirect_tgt;
                        if (rsp.valid) begin
                            // Response arrives with the redirect: drop it now.
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_FLUSH;
                        end
                    end else if (rsp.valid) begin
                        buf_pc_q    <= inflight_pc_q;
                        buf_instr_q <= rsp.data;
                        buf_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // A hand-off coinciding with a redirect still counts;
                    // downstream squashes it.
                    if (redirect_valid_i || if_ready_i) begin
                        if (redirect_valid_i) begin
                            pc_q <= redirect_tgt;
                        end
                        buf_valid_q <= 1'b0;
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (redirect_valid_i) begin
                        pc_q <= redirect_tgt;
                    end
                    if (rsp.valid) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
